// File: rtl/border_unit_pkg.sv
// Shared constants for the border unit: config register map, fixed compare
// defaults and the encoding of the border flag state machine.
package border_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int NUM_REGS = 8;

  typedef enum logic [2:0] {
    ADDR_L38 = 3'd0,
    ADDR_L40 = 3'd1,
    ADDR_R38 = 3'd2,
    ADDR_R40 = 3'd3,
    ADDR_T24 = 3'd4,
    ADDR_T25 = 3'd5,
    ADDR_B24 = 3'd6,
    ADDR_B25 = 3'd7
  } cfg_addr_e;

  localparam int DEF_L38 = 38;
  localparam int DEF_L40 = 31;
  localparam int DEF_R38 = 342;
  localparam int DEF_R40 = 351;
  localparam int DEF_T24 = 55;
  localparam int DEF_T25 = 51;
  localparam int DEF_B24 = 247;
  localparam int DEF_B25 = 251;

  // Encoded as {vborder, main_border}.
  typedef enum logic [1:0] {
    ST_OPEN = 2'b00,
    ST_SIDE = 2'b01,
    ST_VERT = 2'b10,
    ST_BOTH = 2'b11
  } flag_state_e;

  function automatic int cmp_default(input logic [2:0] addr);
    case (addr)
      ADDR_L38: return DEF_L38;
      ADDR_L40: return DEF_L40;
      ADDR_R38: return DEF_R38;
      ADDR_R40: return DEF_R40;
      ADDR_T24: return DEF_T24;
      ADDR_T25: return DEF_T25;
      ADDR_B24: return DEF_B24;
      default:  return DEF_B25;
    endcase
  endfunction

endpackage

// File: rtl/border_unit_cfg_bank.sv
// Programmable compare registers: a pending bank written from the config port,
// an active bank reloaded at frame start, and selection of the effective compares.
module border_cfg_bank
  import border_unit_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk_dot4x,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [XW-1:0] cfg_data,
  input  logic          frame_load,
  input  logic          ext_en,
  input  logic          csel,
  input  logic          rsel,
  output logic [XW-1:0] left,
  output logic [XW-1:0] right,
  output logic [YW-1:0] top,
  output logic [YW-1:0] bottom
);

  logic [XW-1:0] pending [NUM_REGS];
  logic [XW-1:0] active  [NUM_REGS];
  logic [XW-1:0] eff     [NUM_REGS];

  // Active copies the pre-write pending value when a write hits the load edge.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pending[i] <= XW'(cmp_default(3'(i)));
        active[i]  <= XW'(cmp_default(3'(i)));
      end
    end else begin
      if (cfg_we) pending[cfg_addr] <= cfg_data;
      if (frame_load) begin
        for (int i = 0; i < NUM_REGS; i++) active[i] <= pending[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      eff[i] = ext_en ? active[i] : XW'(cmp_default(3'(i)));
    end
  end

  assign left   = csel ? eff[ADDR_L40] : eff[ADDR_L38];
  assign right  = csel ? eff[ADDR_R40] : eff[ADDR_R38];
  assign top    = rsel ? eff[ADDR_T25][YW-1:0] : eff[ADDR_T24][YW-1:0];
  assign bottom = rsel ? eff[ADDR_B25][YW-1:0] : eff[ADDR_B24][YW-1:0];

endmodule

// File: rtl/border_unit.sv
// Border flag generator: vertical/main border flags, per-frame open-border
// statistic and a pipeline-aligned border pixel flag.
//
//   state   | meaning
//   ST_BOTH | vertical border and main border both active (reset state)
//   ST_VERT | vertical border active, main border cleared earlier on the line
//   ST_SIDE | vertical border open, outside the left/right window
//   ST_OPEN | vertical border open, inside the left/right window (display)
module border_unit
  import border_unit_pkg::*;
#(
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int CW   = 7,
  parameter int PIPE = 3
) (
  input  logic          clk_dot4x,
  input  logic          rst_n,
  input  logic          dot_rising,
  input  logic          clk_phi,
  input  logic [CW-1:0] cycle_num,
  input  logic [XW-1:0] xpos,
  input  logic [YW-1:0] raster_line,
  input  logic          rsel,
  input  logic          csel,
  input  logic          den,
  input  logic          ext_en,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [XW-1:0] cfg_data,
  output logic          vborder,
  output logic          main_border,
  output logic          border_px,
  output logic          vopen_frame
);

  logic          frame_load;
  logic [XW-1:0] left, right;
  logic [YW-1:0] top, bottom;
  logic          left_hit, right_hit, top_hit, bottom_hit;

  flag_state_e   state, state_nxt;
  logic          set_vb, set_vb_nxt;
  logic          vb_c, mb_c;
  logic          seen_vb;

  assign frame_load = dot_rising & clk_phi & (raster_line == '0) & (cycle_num == '0);

  border_cfg_bank #(.XW(XW), .YW(YW)) u_cfg_bank (
    .clk_dot4x  (clk_dot4x),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .frame_load (frame_load),
    .ext_en     (ext_en),
    .csel       (csel),
    .rsel       (rsel),
    .left       (left),
    .right      (right),
    .top        (top),
    .bottom     (bottom)
  );

  assign left_hit   = (xpos == left);
  assign right_hit  = (xpos == right);
  assign top_hit    = (raster_line == top);
  assign bottom_hit = (raster_line == bottom);

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_BOTH;
      set_vb <= TRUE;
    end else if (dot_rising) begin
      state  <= state_nxt;
      set_vb <= set_vb_nxt;
    end
  end

  // Evaluated in order so later steps see earlier updates; left wins over right.
  always_comb begin
    vb_c       = state[1];
    mb_c       = state[0];
    set_vb_nxt = set_vb;
    if (left_hit) begin
      if (bottom_hit) set_vb_nxt = TRUE;
      vb_c = set_vb_nxt;
      if (!vb_c) mb_c = FALSE;
    end else if (right_hit) begin
      mb_c = TRUE;
    end
    if (clk_phi) begin
      if (top_hit && den) begin
        vb_c       = FALSE;
        set_vb_nxt = FALSE;
      end
      if (bottom_hit) set_vb_nxt = TRUE;
      if (cycle_num == '0) vb_c = set_vb_nxt;
    end
    state_nxt = flag_state_e'({vb_c, mb_c});
  end

  always_comb begin
    vborder     = state[1];
    main_border = state[0];
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      vopen_frame <= FALSE;
      seen_vb     <= FALSE;
    end else if (dot_rising) begin
      if (frame_load) begin
        vopen_frame <= ~seen_vb;
        seen_vb     <= vborder;
      end else begin
        seen_vb <= seen_vb | vborder;
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign border_px = main_border;
    end else begin : g_pipe
      logic [PIPE-1:0] pipe;
      always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) pipe <= '1;
        else if (dot_rising) pipe <= (pipe << 1) | PIPE'(main_border);
      end
      assign border_px = pipe[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_border_unit.sv
// Self-checking bench for border_unit: vector tables for the basic flag behaviour
// and hand sequences for config shadowing, open-border frames and reset.
`timescale 1ns/1ps
module tb_border_unit;

  localparam int XW = 10, YW = 9, CW = 7, PIPE = 3;

  logic          clk_dot4x = 1'b0;
  logic          rst_n = 1'b0;
  logic          dot_rising = 1'b0, clk_phi = 1'b0;
  logic [CW-1:0] cycle_num = '0;
  logic [XW-1:0] xpos = '0;
  logic [YW-1:0] raster_line = '0;
  logic          rsel = 1'b1, csel = 1'b1, den = 1'b1, ext_en = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [XW-1:0] cfg_data = '0;
  logic          vborder, main_border, border_px, vopen_frame;

  always #5 clk_dot4x = ~clk_dot4x;

  border_unit #(.XW(XW), .YW(YW), .CW(CW), .PIPE(PIPE)) dut (
    .clk_dot4x  (clk_dot4x),
    .rst_n      (rst_n),
    .dot_rising (dot_rising),
    .clk_phi    (clk_phi),
    .cycle_num  (cycle_num),
    .xpos       (xpos),
    .raster_line(raster_line),
    .rsel       (rsel),
    .csel       (csel),
    .den        (den),
    .ext_en     (ext_en),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .vborder    (vborder),
    .main_border(main_border),
    .border_px  (border_px),
    .vopen_frame(vopen_frame)
  );

  typedef struct {
    logic ext, rs, cs, dn, dr, phi;
    int   cyc, x, line;
    logic we;
    int   addr, data;
    logic vb, mb, vo;
  } vec_t;

  typedef struct {
    logic vb, mb, px, vo;
    int   step;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0, n_err = 0, step_no = 0;
  logic g_ext = 1'b0, g_rs = 1'b1, g_cs = 1'b1, g_dn = 1'b1;
  logic [PIPE-1:0] hist = '1;
  logic cur_vb = 1'b1, cur_mb = 1'b1, cur_vo = 1'b0;
  string tag = "init";

  function automatic vec_t v(input logic dr, input logic phi, input int cyc, input int x,
                             input int line, input logic vb, input logic mb, input logic vo);
    vec_t r;
    r.ext = g_ext; r.rs = g_rs; r.cs = g_cs; r.dn = g_dn;
    r.dr = dr; r.phi = phi; r.cyc = cyc; r.x = x; r.line = line;
    r.we = 1'b0; r.addr = 0; r.data = 0;
    r.vb = vb; r.mb = mb; r.vo = vo;
    return r;
  endfunction

  task automatic cmp(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s step %0d: got %b expected %b", tag, name, step_no, act, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s/scoreboard step %0d: got empty queue expected entry", tag, step_no);
    end else begin
      e = sb.pop_front();
      cmp("vborder", vborder, e.vb);
      cmp("main_border", main_border, e.mb);
      cmp("border_px", border_px, e.px);
      cmp("vopen_frame", vopen_frame, e.vo);
    end
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clk_dot4x);
    ext_en = t.ext; rsel = t.rs; csel = t.cs; den = t.dn;
    dot_rising = t.dr; clk_phi = t.phi;
    cycle_num = CW'(t.cyc); xpos = XW'(t.x); raster_line = YW'(t.line);
    cfg_we = t.we; cfg_addr = 3'(t.addr); cfg_data = XW'(t.data);
    if (t.dr) hist = (hist << 1) | PIPE'(cur_mb);
    cur_vb = t.vb; cur_mb = t.mb; cur_vo = t.vo;
    e.vb = t.vb; e.mb = t.mb; e.vo = t.vo; e.px = hist[PIPE-1]; e.step = step_no;
    sb.push_back(e);
    @(posedge clk_dot4x);
    #1;
    dot_rising = 1'b0; cfg_we = 1'b0;
    check_outputs();
    step_no++;
  endtask

  task automatic cfg_write(input int addr, input int data);
    vec_t t;
    t = v(1'b0, 1'b0, 5, 0, 61, cur_vb, cur_mb, cur_vo);
    t.we = 1'b1; t.addr = addr; t.data = data;
    apply(t);
  endtask

  // Reset is asserted between edges so only an asynchronous reset shows up at once.
  task automatic do_reset();
    @(negedge clk_dot4x);
    dot_rising = 1'b0; cfg_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_vborder", vborder, 1'b1);
    cmp("rst_main_border", main_border, 1'b1);
    cmp("rst_border_px", border_px, 1'b1);
    cmp("rst_vopen_frame", vopen_frame, 1'b0);
    repeat (2) @(posedge clk_dot4x);
    @(negedge clk_dot4x);
    rst_n = 1'b1;
    hist = '1; cur_vb = 1'b1; cur_mb = 1'b1; cur_vo = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t t;

    // Fixed compares, 40 columns / 25 rows: top clear, window, pipe delay, 38-column compares.
    tag = "basic";
    g_ext = 1'b0; g_rs = 1'b1; g_cs = 1'b1; g_dn = 1'b1;
    do_reset();
    tbl.delete();
    tbl.push_back(v(1, 1, 0,   0,  51, 0, 1, 0));
    tbl.push_back(v(0, 0, 5,  31,  52, 0, 1, 0));
    tbl.push_back(v(1, 0, 5,  31,  52, 0, 0, 0));
    tbl.push_back(v(1, 0, 5, 351,  52, 0, 1, 0));
    tbl.push_back(v(1, 0, 5,   0,  52, 0, 1, 0));
    tbl.push_back(v(1, 0, 5,   0,  52, 0, 1, 0));
    tbl.push_back(v(1, 0, 5,   0,  52, 0, 1, 0));
    g_cs = 1'b0;
    tbl.push_back(v(1, 0, 5,  31,  52, 0, 1, 0));
    tbl.push_back(v(1, 0, 5,  38,  52, 0, 0, 0));
    tbl.push_back(v(1, 0, 5, 342,  52, 0, 1, 0));
    g_cs = 1'b1;
    tbl.push_back(v(1, 1, 3,   0, 251, 0, 1, 0));
    tbl.push_back(v(1, 1, 0,   0, 252, 1, 1, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // den low across the top line keeps the border closed; first load after reset reports open.
    tag = "den_off";
    g_dn = 1'b0;
    do_reset();
    tbl.delete();
    tbl.push_back(v(1, 1, 0,   0,   0, 1, 1, 1));
    tbl.push_back(v(1, 1, 0,   0,  51, 1, 1, 1));
    tbl.push_back(v(1, 0, 5,  31,  52, 1, 1, 1));
    tbl.push_back(v(1, 0, 5, 351,  52, 1, 1, 1));
    tbl.push_back(v(1, 1, 0,   0, 251, 1, 1, 1));
    tbl.push_back(v(1, 1, 0,   0,   0, 1, 1, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Mid-frame write to T25 takes effect only after the next frame load.
    tag = "shadow_top";
    g_dn = 1'b1; g_ext = 1'b1;
    do_reset();
    cfg_write(5, 60);
    apply(v(1, 1, 0, 0,  51, 0, 1, 0));
    apply(v(1, 1, 0, 0, 251, 1, 1, 0));
    apply(v(1, 1, 0, 0,   0, 1, 1, 0));
    apply(v(1, 1, 0, 0,  51, 1, 1, 0));
    apply(v(1, 1, 0, 0,  60, 0, 1, 0));

    // Write landing on the frame-load edge waits one more frame.
    tag = "write_on_load";
    apply(v(1, 1, 0, 0, 251, 1, 1, 0));
    t = v(1, 1, 0, 0, 0, 1, 1, 0);
    t.we = 1'b1; t.addr = 1; t.data = 40;
    apply(t);
    apply(v(1, 1, 0,   0,  60, 0, 1, 0));
    apply(v(1, 0, 5,  40,  61, 0, 1, 0));
    apply(v(1, 0, 5,  31,  61, 0, 0, 0));
    apply(v(1, 0, 5, 351,  61, 0, 1, 0));
    apply(v(1, 1, 0,   0, 251, 1, 1, 0));
    apply(v(1, 1, 0,   0,   0, 1, 1, 0));
    apply(v(1, 1, 0,   0,  60, 0, 1, 0));
    apply(v(1, 0, 5,  31,  61, 0, 1, 0));
    apply(v(1, 0, 5,  40,  61, 0, 0, 0));
    apply(v(1, 0, 5, 351,  61, 0, 1, 0));

    // Bottom skipped by switching to 24 rows: the frame that starts open reports it.
    tag = "open_frame";
    g_rs = 1'b0;
    apply(v(1, 1, 0, 0, 250, 0, 1, 0));
    apply(v(1, 1, 0, 0, 251, 0, 1, 0));
    g_rs = 1'b1;
    apply(v(1, 1, 0, 0,   0, 0, 1, 0));
    apply(v(1, 1, 0, 0,  60, 0, 1, 0));
    g_rs = 1'b0;
    apply(v(1, 1, 0, 0, 251, 0, 1, 0));
    g_rs = 1'b1;
    apply(v(1, 1, 0, 0,   0, 0, 1, 1));
    apply(v(1, 1, 0, 0,  60, 0, 1, 1));
    apply(v(1, 1, 0, 0, 251, 1, 1, 1));
    apply(v(1, 0, 5, 0, 252, 1, 1, 1));
    apply(v(1, 1, 0, 0,   0, 1, 1, 0));

    // Left and right compares equal: left branch runs, right is not applied.
    tag = "left_eq_right";
    cfg_write(1, 100);
    cfg_write(3, 100);
    apply(v(1, 1, 0,   0,  0, 1, 1, 0));
    apply(v(1, 1, 0,   0, 60, 0, 1, 0));
    apply(v(1, 0, 5, 100, 61, 0, 0, 0));
    apply(v(1, 0, 5, 351, 61, 0, 0, 0));
    apply(v(1, 0, 5, 100, 61, 0, 0, 0));
    g_ext = 1'b0;
    apply(v(1, 0, 5, 351, 61, 0, 1, 0));
    g_ext = 1'b1;

    // Reset mid-frame restores flags and compare banks to defaults.
    tag = "mid_reset";
    do_reset();
    apply(v(1, 0, 5, 31, 61, 1, 1, 0));
    apply(v(1, 1, 0,  0, 60, 1, 1, 0));
    apply(v(1, 1, 0,  0, 51, 0, 1, 0));
    apply(v(1, 0, 5, 31, 52, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
